// File: rtl/level_sampler_pkg.sv
// Shared definitions for the tank-level bus. The indicator-side checker uses
// the same package.
//
// Contents:
//   LS_N_LEVELS_DEF  default number of float switches (bit 0 = lowest)
//   LS_VEC_W         width the helper functions work at (zero-extended input)
//   ST_RUN/ST_FAULT  validator state encoding
//   ls_is_thermo()   1 when the vector is a legal thermometer code
//   ls_popcount()    number of set bits (3-bit result, up to 7 levels)
package level_sampler_pkg;

    localparam int LS_N_LEVELS_DEF = 6;
    localparam int LS_VEC_W        = 8;

    localparam logic [0:0] ST_RUN   = 1'b0;
    localparam logic [0:0] ST_FAULT = 1'b1;

    // Callers zero-extend to LS_VEC_W. The carry out of the top real bit lands
    // in a zero bit, so the result is the same as checking at the real width.
    function automatic logic ls_is_thermo(input logic [LS_VEC_W-1:0] v);
        return ((v & (v + LS_VEC_W'(1))) == '0);
    endfunction

    function automatic logic [2:0] ls_popcount(input logic [LS_VEC_W-1:0] v);
        logic [2:0] cnt;
        cnt = '0;
        for (int i = 0; i < LS_VEC_W - 1; i++) begin
            cnt = cnt + 3'(v[i]);
        end
        return cnt;
    endfunction

endpackage

// File: rtl/level_sampler_bit_debouncer.sv
// One float-switch channel: a two-flop synchroniser followed by a debounce
// counter and the accepted (stable) value.
//
// Ports:
//   clk       system clock
//   rst_n     synchronous active-low reset
//   i_raw     raw switch input, asynchronous, may bounce
//   o_stable  debounced value
//
// A clean edge on i_raw reaches o_stable 2 + DEBOUNCE_CYCLES edges later.
module bit_debouncer #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_raw,
    output logic o_stable
);

    logic             r_meta;
    logic             r_sync;
    logic [CNT_W-1:0] r_cnt;
    logic             r_stable;
    logic             w_tc;

    assign w_tc = (r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_meta   <= 1'b0;
            r_sync   <= 1'b0;
            r_cnt    <= '0;
            r_stable <= 1'b0;
        end else begin
            r_meta <= i_raw;
            r_sync <= r_meta;
            // Any return to the stable value restarts the count, so a glitch
            // shorter than DEBOUNCE_CYCLES never gets accepted.
            if (r_sync == r_stable) begin
                r_cnt <= '0;
            end else if (w_tc) begin
                r_stable <= r_sync;
                r_cnt    <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign o_stable = r_stable;

endmodule

// File: rtl/level_sampler.sv
// Producer end of the tank-level bus. Debounces the float switches, checks the
// debounced vector is a thermometer code and publishes it with a count and a
// one-cycle update strobe. Flags physically impossible switch patterns.
//
// Ports:
//   clk          system clock
//   rst_n        synchronous active-low reset
//   raw_sw       raw float switches (bit 0 = lowest), asynchronous
//   levels       published thermometer level
//   level_count  set bits in levels
//   level_upd    one-cycle pulse in the cycle levels takes a new value
//   fault        high while the debounced vector is not a thermometer code
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_RUN   | debounced vector legal; levels tracks it
// ST_FAULT | debounced vector illegal; levels/level_count frozen
module level_sampler
    import level_sampler_pkg::*;
#(
    parameter int N_LEVELS        = LS_N_LEVELS_DEF,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [N_LEVELS-1:0] raw_sw,
    output logic [N_LEVELS-1:0] levels,
    output logic [2:0]          level_count,
    output logic                level_upd,
    output logic                fault
);

    logic [N_LEVELS-1:0] w_stable;
    logic [LS_VEC_W-1:0] w_stable_ext;
    logic                w_legal;
    logic                w_diff;

    logic [0:0]          r_state;
    logic [N_LEVELS-1:0] r_levels;
    logic [2:0]          r_count;
    logic                r_upd;
    logic                r_fault;

    for (genvar i = 0; i < N_LEVELS; i++) begin : g_bit
        bit_debouncer #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W)
        ) u_deb (
            .clk     (clk),
            .rst_n   (rst_n),
            .i_raw   (raw_sw[i]),
            .o_stable(w_stable[i])
        );
    end

    assign w_stable_ext = {{(LS_VEC_W - N_LEVELS){1'b0}}, w_stable};
    assign w_legal      = ls_is_thermo(w_stable_ext);
    assign w_diff       = (w_stable != r_levels);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= ST_RUN;
            r_levels <= '0;
            r_count  <= '0;
            r_upd    <= 1'b0;
            r_fault  <= 1'b0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (!w_legal) begin
                        r_state <= ST_FAULT;
                        r_fault <= 1'b1;
                        r_upd   <= 1'b0;
                    end else if (w_diff) begin
                        r_levels <= w_stable;
                        r_count  <= ls_popcount(w_stable_ext);
                        r_upd    <= 1'b1;
                    end else begin
                        r_upd <= 1'b0;
                    end
                end
                ST_FAULT: begin
                    r_upd <= 1'b0;
                    if (w_legal) begin
                        r_state <= ST_RUN;
                        r_fault <= 1'b0;
                        // Leaving fault straight onto a new level publishes it
                        // in the same cycle.
                        if (w_diff) begin
                            r_levels <= w_stable;
                            r_count  <= ls_popcount(w_stable_ext);
                            r_upd    <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= ST_RUN;
                    r_upd   <= 1'b0;
                end
            endcase
        end
    end

    assign levels      = r_levels;
    assign level_count = r_count;
    assign level_upd   = r_upd;
    assign fault       = r_fault;

endmodule

// File: tb/tb_level_sampler.sv
module tb_level_sampler;

    logic       clk;
    logic       rst_n;
    logic [5:0] raw_sw;
    logic [5:0] levels;
    logic [2:0] level_count;
    logic       level_upd;
    logic       fault;

    int n_tests;
    int n_fail;

    level_sampler #(
        .N_LEVELS       (6),
        .DEBOUNCE_CYCLES(4),
        .CNT_W          (16)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .raw_sw     (raw_sw),
        .levels     (levels),
        .level_count(level_count),
        .level_upd  (level_upd),
        .fault      (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic       rst_n;
        logic [5:0] raw;
        int         ncyc;
        logic [5:0] lv;
        logic [2:0] cnt;
        logic       upd;
        logic       flt;
        int         npulse;
        int         nfault;
    } vec_t;

    vec_t qa[$];
    vec_t qb[$];

    function automatic vec_t mk(string name, logic rn, logic [5:0] raw, int ncyc,
                                logic [5:0] lv, logic [2:0] cnt, logic upd,
                                logic flt, int npulse, int nfault);
        vec_t v;
        v.name = name; v.rst_n = rn; v.raw = raw; v.ncyc = ncyc;
        v.lv = lv; v.cnt = cnt; v.upd = upd; v.flt = flt;
        v.npulse = npulse; v.nfault = nfault;
        return v;
    endfunction

    task automatic chk(string name, int act, int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic run_vec(vec_t v);
        int pulses;
        int nf;
        pulses = 0;
        nf     = 0;
        rst_n  = v.rst_n;
        raw_sw = v.raw;
        repeat (v.ncyc) begin
            @(posedge clk);
            #1;
            if (level_upd) pulses++;
            if (fault) nf++;
        end
        chk({v.name, " levels"}, int'(levels), int'(v.lv));
        chk({v.name, " level_count"}, int'(level_count), int'(v.cnt));
        chk({v.name, " level_upd"}, int'(level_upd), int'(v.upd));
        chk({v.name, " fault"}, int'(fault), int'(v.flt));
        chk({v.name, " upd pulses"}, pulses, v.npulse);
        chk({v.name, " fault cycles"}, nf, v.nfault);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst_n   = 1'b0;
        raw_sw  = 6'h3F;

        //            name               rn  raw    cyc lv     cnt upd flt pul nf
        qa.push_back(mk("t1 reset",      0, 6'h3F, 3, 6'h00, 0, 0, 0, 0, 0));
        qa.push_back(mk("t1 release",    1, 6'h00, 10, 6'h00, 0, 0, 0, 0, 0));
        qa.push_back(mk("t2 pre",        1, 6'h07, 6, 6'h00, 0, 0, 0, 0, 0));
        qa.push_back(mk("t2 edge7",      1, 6'h07, 1, 6'h07, 3, 1, 0, 1, 0));
        qa.push_back(mk("t2 after",      1, 6'h07, 1, 6'h07, 3, 0, 0, 0, 0));
        qa.push_back(mk("t3 glitch",     1, 6'h0F, 3, 6'h07, 3, 0, 0, 0, 0));
        qa.push_back(mk("t3 settle",     1, 6'h07, 10, 6'h07, 3, 0, 0, 0, 0));
        qa.push_back(mk("t3 glitch2",    1, 6'h0F, 3, 6'h07, 3, 0, 0, 0, 0));
        qa.push_back(mk("t3 settle2",    1, 6'h07, 10, 6'h07, 3, 0, 0, 0, 0));
        qa.push_back(mk("t4 pre",        1, 6'h17, 6, 6'h07, 3, 0, 0, 0, 0));
        qa.push_back(mk("t4 fault",      1, 6'h17, 1, 6'h07, 3, 0, 1, 0, 1));
        qa.push_back(mk("t4 clr same",   1, 6'h07, 7, 6'h07, 3, 0, 0, 0, 6));
        qa.push_back(mk("t4 refault",    1, 6'h17, 7, 6'h07, 3, 0, 1, 0, 1));
        qa.push_back(mk("t4 fix pre",    1, 6'h1F, 6, 6'h07, 3, 0, 1, 0, 6));
        qa.push_back(mk("t4 fix",        1, 6'h1F, 1, 6'h1F, 5, 1, 0, 1, 0));
        qa.push_back(mk("t4 fix after",  1, 6'h1F, 1, 6'h1F, 5, 0, 0, 0, 0));
        qa.push_back(mk("t5 full",       1, 6'h3F, 7, 6'h3F, 6, 1, 0, 1, 0));
        qa.push_back(mk("t5 settle",     1, 6'h3F, 2, 6'h3F, 6, 0, 0, 0, 0));

        qb.push_back(mk("t6 drain",      1, 6'h00, 7, 6'h00, 0, 1, 0, 1, 0));
        qb.push_back(mk("t6 empty",      1, 6'h00, 3, 6'h00, 0, 0, 0, 0, 0));
        qb.push_back(mk("t6 fill all",   1, 6'h3F, 7, 6'h3F, 6, 1, 0, 1, 0));
        qb.push_back(mk("t6 full hold",  1, 6'h3F, 3, 6'h3F, 6, 0, 0, 0, 0));

        foreach (qa[i]) run_vec(qa[i]);

        // Reset two edges into a debounce toward 011111, then the debounce
        // must restart from scratch: full 7-edge latency after release, with
        // no strobe on reset exit.
        raw_sw = 6'h1F;
        repeat (2) begin
            @(posedge clk);
            #1;
            chk("t5 mid-debounce levels", int'(levels), 'h3F);
        end
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("t5 in-reset levels", int'(levels), 0);
        chk("t5 in-reset count", int'(level_count), 0);
        chk("t5 in-reset upd", int'(level_upd), 0);
        chk("t5 in-reset fault", int'(fault), 0);
        rst_n = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("t5 restart upd edge%0d", k), int'(level_upd), (k == 7) ? 1 : 0);
            chk($sformatf("t5 restart levels edge%0d", k), int'(levels), (k >= 7) ? 'h1F : 0);
            chk($sformatf("t5 restart fault edge%0d", k), int'(fault), 0);
        end
        chk("t5 restart count", int'(level_count), 5);

        foreach (qb[i]) run_vec(qb[i]);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
